// File: rtl/crc_sched_pkg.sv
// Shared types and constants for the CRC job scheduler.
// Optional build macro used by crc_job_sched: CRC_JOB_SCHED_TIMEOUT_EN.
package crc_sched_pkg;

    localparam int unsigned MSG_W       = 60;
    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/crc_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request
// at or above ptr, wrapping via a double-width masked priority search.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant
);

    localparam int unsigned DW = 2 * N_REQ;

    logic [DW-1:0] dbl;
    logic [DW-1:0] mask;
    logic [DW-1:0] masked;
    logic          found;

    // Upper copy of req supplies the wrapped candidates below ptr.
    always_comb begin
        dbl    = {req, req};
        mask   = ~((DW'(1) << ptr) - DW'(1));
        masked = dbl & mask;
        grant  = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (masked[i] && !found) begin
                grant[i % N_REQ] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_job_sched.sv
// Round-robin scheduler sharing one CRC pipeline among N_REQ requesters, one job in flight.
// Optional macro CRC_JOB_SCHED_TIMEOUT_EN adds a WAIT-state timeout reported on rsp_err.
module crc_job_sched
    import crc_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned ID_W  = $clog2(N_REQ),
    parameter int unsigned MSG_W = crc_sched_pkg::MSG_W
`ifdef CRC_JOB_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic                   clk_1,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*MSG_W-1:0] req_message,
    input  logic [N_REQ-1:0]       req_CRC,
    input  logic [N_REQ-1:0]       req_mode,
    output logic                   crc_in_valid,
    output logic                   crc_CRC,
    output logic                   crc_mode,
    output logic [MSG_W-1:0]       crc_message,
    input  logic                   crc_out_valid,
    input  logic [MSG_W-1:0]       crc_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [MSG_W-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    sched_state_e     state_q, state_d;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  job_id_q, job_id_d;
    logic [ID_W-1:0]  grant_idx;
    logic [MSG_W-1:0] grant_msg;
    logic             grant_crc, grant_mode;
    logic             transfer;
    logic             timeout_hit;

    logic             crc_in_valid_d, crc_CRC_d, crc_mode_d;
    logic [MSG_W-1:0] crc_message_d;
    logic             rsp_valid_d, rsp_err_d, busy_d;
    logic [ID_W-1:0]  rsp_id_d;
    logic [MSG_W-1:0] rsp_data_d;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant : '0;
    assign transfer  = |req_ready;

    // Index and payload of the granted requester.
    always_comb begin
        grant_idx  = '0;
        grant_msg  = '0;
        grant_crc  = 1'b0;
        grant_mode = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx  = ID_W'(i);
                grant_msg  = req_message[i*MSG_W +: MSG_W];
                grant_crc  = req_CRC[i];
                grant_mode = req_mode[i];
            end
        end
    end

`ifdef CRC_JOB_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt_q;

    assign timeout_hit = (state_q == ST_WAIT) && (to_cnt_q == CNT_W'(TIMEOUT - 1));

    // Counts WAIT cycles; held at zero in every other state.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        job_id_d       = job_id_q;
        crc_in_valid_d = 1'b0;
        crc_CRC_d      = crc_CRC;
        crc_mode_d     = crc_mode;
        crc_message_d  = crc_message;
        rsp_valid_d    = rsp_valid;
        rsp_id_d       = rsp_id;
        rsp_data_d     = rsp_data;
        rsp_err_d      = rsp_err;

        unique case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d        = ST_ISSUE;
                    job_id_d       = grant_idx;
                    crc_in_valid_d = 1'b1;
                    crc_CRC_d      = grant_crc;
                    crc_mode_d     = grant_mode;
                    crc_message_d  = grant_msg;
                    rr_ptr_d       = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (crc_out_valid) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = job_id_q;
                    rsp_data_d  = crc_out;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = job_id_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            job_id_q     <= '0;
            crc_in_valid <= 1'b0;
            crc_CRC      <= 1'b0;
            crc_mode     <= 1'b0;
            crc_message  <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            job_id_q     <= job_id_d;
            crc_in_valid <= crc_in_valid_d;
            crc_CRC      <= crc_CRC_d;
            crc_mode     <= crc_mode_d;
            crc_message  <= crc_message_d;
            rsp_valid    <= rsp_valid_d;
            rsp_id       <= rsp_id_d;
            rsp_data     <= rsp_data_d;
            rsp_err      <= rsp_err_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_crc_job_sched.sv
// Bench for crc_job_sched: table of arbitration jobs with a response scoreboard,
// plus hand-written stray-completion, timeout/stall and mid-job reset sequences.
module tb_crc_job_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned MW = 60;

    logic              clk_1 = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*MW-1:0]   req_message;
    logic [N-1:0]      req_CRC;
    logic [N-1:0]      req_mode;
    logic              crc_in_valid;
    logic              crc_CRC;
    logic              crc_mode;
    logic [MW-1:0]     crc_message;
    logic              crc_out_valid;
    logic [MW-1:0]     crc_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [MW-1:0]     rsp_data;
    logic              rsp_err;
    logic              busy;

    always #5 clk_1 = ~clk_1;

    crc_job_sched dut (
        .clk_1         (clk_1),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_message   (req_message),
        .req_CRC       (req_CRC),
        .req_mode      (req_mode),
        .crc_in_valid  (crc_in_valid),
        .crc_CRC       (crc_CRC),
        .crc_mode      (crc_mode),
        .crc_message   (crc_message),
        .crc_out_valid (crc_out_valid),
        .crc_out       (crc_out),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    typedef struct {
        logic [N-1:0]  vec;
        logic [N-1:0]  grant;
        logic [MW-1:0] msg;
        logic [MW-1:0] res;
        logic          crc;
        logic          mode;
        int            lat;
        int            bp;
    } vec_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [MW-1:0] data;
    } exp_t;

    int            total = 0;
    int            bad   = 0;
    exp_t          sb[$];
    logic [MW-1:0] last_data;
    vec_t          tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] vec, input logic [N-1:0] grant,
                                input int lat, input int bp, input int k);
        vec_t r;
        r.vec   = vec;
        r.grant = grant;
        r.msg   = {28'($urandom), 32'($urandom)};
        r.res   = {28'($urandom), 32'($urandom)};
        r.crc   = k[0];
        r.mode  = k[1];
        r.lat   = lat;
        r.bp    = bp;
        return r;
    endfunction

    // Present a request (granted requester gets msg, others get decoys) and check ISSUE.
    task automatic start_job(input logic [N-1:0] vec, input logic [N-1:0] grant,
                             input logic [MW-1:0] msg, input logic crc, input logic mode,
                             output int gidx);
        @(posedge clk_1); #1;
        rsp_ready     = 1'b0;
        crc_out_valid = 1'b0;
        gidx = 0;
        for (int i = 0; i < int'(N); i++) if (grant[i]) gidx = i;
        req_valid = vec;
        for (int i = 0; i < int'(N); i++) begin
            req_message[i*MW +: MW] = (i == gidx) ? msg : (~msg ^ MW'(i + 1));
            req_CRC[i]  = (i == gidx) ? crc  : ~crc;
            req_mode[i] = (i == gidx) ? mode : ~mode;
        end
        @(negedge clk_1);
        check("req_ready_grant", 64'(req_ready), 64'(grant));
        @(posedge clk_1); #1;
        req_valid   = '0;
        req_message = '0;
        req_CRC     = '0;
        req_mode    = '0;
        @(negedge clk_1);
        if (grant == '0) begin
            check("idle_no_launch", 64'(crc_in_valid), 64'(0));
            check("idle_not_busy", 64'(busy), 64'(0));
            return;
        end
        check("launch_valid", 64'(crc_in_valid), 64'(1));
        check("launch_msg", 64'(crc_message), 64'(msg));
        check("launch_crc", 64'(crc_CRC), 64'(crc));
        check("launch_mode", 64'(crc_mode), 64'(mode));
        check("issue_busy", 64'(busy), 64'(1));
    endtask

    task automatic run_job(input vec_t r);
        int   g;
        exp_t e;
        start_job(r.vec, r.grant, r.msg, r.crc, r.mode, g);
        if (r.grant == '0) return;
        for (int i = 1; i <= r.lat; i++) begin
            @(posedge clk_1); #1;
            if (i == r.lat) begin
                crc_out_valid = 1'b1;
                crc_out       = r.res;
                e.id   = IW'(g);
                e.data = r.res;
                sb.push_back(e);
            end
            @(negedge clk_1);
            check("launch_one_cycle", 64'(crc_in_valid), 64'(0));
            check("no_early_rsp", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk_1); #1;
        crc_out_valid = 1'b0;
        crc_out       = '0;
        req_valid     = r.vec;
        @(negedge clk_1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got empty queue expected one entry");
            return;
        end
        e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_err", 64'(rsp_err), 64'(0));
        check("resp_ready_low", 64'(req_ready), 64'(0));
        for (int b = 0; b < r.bp; b++) begin
            @(posedge clk_1); #1;
            crc_out_valid = 1'b1;
            crc_out       = ~r.res;
            @(negedge clk_1);
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_id", 64'(rsp_id), 64'(e.id));
            check("bp_data", 64'(rsp_data), 64'(e.data));
            check("bp_ready_low", 64'(req_ready), 64'(0));
            check("bp_busy", 64'(busy), 64'(1));
        end
        @(posedge clk_1); #1;
        crc_out_valid = 1'b0;
        rsp_ready     = 1'b1;
        @(negedge clk_1);
        check("hs_valid", 64'(rsp_valid), 64'(1));
        last_data = e.data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        rst_n         = 1'b0;
        req_valid     = '0;
        req_message   = '0;
        req_CRC       = '0;
        req_mode      = '0;
        crc_out_valid = 1'b0;
        crc_out       = '0;
        rsp_ready     = 1'b0;
        last_data     = '0;

        tbl[0] = '{vec: 4'b0001, grant: 4'b0001, msg: 60'h0123456789ABCDE,
                   res: 60'hFEDCBA987654321, crc: 1'b1, mode: 1'b0, lat: 8, bp: 0};
        tbl[1]  = mk(4'b1111, 4'b0010, 3, 0, 1);
        tbl[2]  = mk(4'b1111, 4'b0100, 3, 0, 2);
        tbl[3]  = mk(4'b1111, 4'b1000, 3, 0, 3);
        tbl[4]  = mk(4'b1111, 4'b0001, 3, 0, 4);
        tbl[5]  = mk(4'b1111, 4'b0010, 3, 0, 5);
        tbl[6]  = mk(4'b1111, 4'b0100, 3, 0, 6);
        tbl[7]  = mk(4'b0011, 4'b0001, 2, 0, 7);
        tbl[8]  = mk(4'b0011, 4'b0010, 2, 0, 8);
        tbl[9]  = mk(4'b0100, 4'b0100, 4, 5, 9);
        tbl[10] = mk(4'b1001, 4'b1000, 2, 0, 10);
        tbl[11] = mk(4'b1001, 4'b0001, 5, 1, 11);
        tbl[12] = mk(4'b1100, 4'b0100, 1, 0, 12);
        tbl[13] = mk(4'b0000, 4'b0000, 1, 0, 13);
        tbl[14] = mk(4'b1111, 4'b0001, 3, 0, 14);

        repeat (3) @(posedge clk_1);
        @(negedge clk_1);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_launch", 64'(crc_in_valid), 64'(0));
        check("rst_msg", 64'(crc_message), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_job(tbl[i]);

        // Stray completion in IDLE must not disturb anything.
        @(posedge clk_1); #1;
        rsp_ready     = 1'b0;
        req_valid     = '0;
        crc_out_valid = 1'b1;
        crc_out       = 60'h1;
        @(posedge clk_1); #1;
        crc_out_valid = 1'b0;
        @(negedge clk_1);
        check("stray_rsp_valid", 64'(rsp_valid), 64'(0));
        check("stray_busy", 64'(busy), 64'(0));
        check("stray_rsp_data", 64'(rsp_data), 64'(last_data));

        // Job to requester 2 that never completes (pointer at 3 beforehand).
        start_job(4'b0100, 4'b0100, 60'hABCDEF012345678, 1'b0, 1'b1, g);
`ifdef CRC_JOB_SCHED_TIMEOUT_EN
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk_1); #1;
            @(negedge clk_1);
            if (i == 64) check("to_not_yet", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk_1); #1;
        @(negedge clk_1);
        check("to_rsp_valid", 64'(rsp_valid), 64'(1));
        check("to_rsp_err", 64'(rsp_err), 64'(1));
        check("to_rsp_data", 64'(rsp_data), 64'(0));
        check("to_rsp_id", 64'(rsp_id), 64'(2));
        @(posedge clk_1); #1;
        rsp_ready = 1'b1;
        start_job(4'b0100, 4'b0100, 60'h0F0F0F0F0F0F0F0, 1'b1, 1'b1, g);
        repeat (5) @(posedge clk_1);
`else
        repeat (100) @(posedge clk_1);
        @(negedge clk_1);
        check("stall_no_rsp", 64'(rsp_valid), 64'(0));
        check("stall_busy", 64'(busy), 64'(1));
        check("stall_err", 64'(rsp_err), 64'(0));
`endif

        // Asynchronous reset while waiting drops the job.
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_msg", 64'(crc_message), 64'(0));
        check("arst_crc", 64'(crc_CRC), 64'(0));
        check("arst_mode", 64'(crc_mode), 64'(0));
        check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("arst_rsp_data", 64'(rsp_data), 64'(0));
        @(negedge clk_1);
        rst_n = 1'b1;
        @(posedge clk_1); #1;
        crc_out_valid = 1'b1;
        crc_out       = 60'h5A5A5A5A5A5A5A5;
        @(posedge clk_1); #1;
        crc_out_valid = 1'b0;
        @(negedge clk_1);
        check("late_cpl_rsp", 64'(rsp_valid), 64'(0));
        check("late_cpl_busy", 64'(busy), 64'(0));

        // Pointer back at 0: full request set must grant requester 0.
        run_job(tbl[14]);
        @(posedge clk_1); #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        @(negedge clk_1);
        check("end_idle", 64'(busy), 64'(0));
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
